// File: rtl/cga_mode_init_if.sv
// I/O-side host bus between the mode initiator and a CGA adapter.
// The initiator owns address, data, strobes and aen; the adapter returns read data and rdy.
interface cga_mode_init_if;
    logic [14:0] bus_a;
    logic [7:0]  bus_d;
    logic [7:0]  bus_in;
    logic        bus_ior_l;
    logic        bus_iow_l;
    logic        bus_aen;
    logic        bus_rdy;

    modport master (
        output bus_a, bus_d, bus_ior_l, bus_iow_l, bus_aen,
        input  bus_in, bus_rdy
    );

    modport slave (
        input  bus_a, bus_d, bus_ior_l, bus_iow_l, bus_aen,
        output bus_in, bus_rdy
    );
endinterface

// File: rtl/cga_mode_init.sv
// Programs a CGA adapter into one of four BIOS video modes over ISA I/O cycles:
// optional vsync poll, video off, 16 CRTC registers, colour, then the final mode write.
module cga_mode_init #(
    parameter logic [15:0] IO_BASE_ADDR = 16'h3d0,
    parameter int          SETUP_CYC    = 2,
    parameter int          STROBE_CYC   = 4,
    parameter int          HOLD_CYC     = 2,
    parameter int          WAIT_VSYNC   = 0,
    parameter logic [15:0] POLL_TIMEOUT = 16'd4096
) (
    input  logic           clk,
    input  logic           reset_l,
    input  logic           start,
    input  logic [1:0]     mode_sel,
    output logic           busy,
    output logic           done,
    output logic           timeout,
    cga_mode_init_if.master bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_SETUP  = 3'd1;
    localparam logic [2:0] S_RD_STROBE = 3'd2;
    localparam logic [2:0] S_RD_HOLD   = 3'd3;
    localparam logic [2:0] S_WR_SETUP  = 3'd4;
    localparam logic [2:0] S_WR_STROBE = 3'd5;
    localparam logic [2:0] S_WR_HOLD   = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [3:0] OFF_INDEX  = 4'h4;
    localparam logic [3:0] OFF_DATA   = 4'h5;
    localparam logic [3:0] OFF_MODE   = 4'h8;
    localparam logic [3:0] OFF_COLOUR = 4'h9;
    localparam logic [3:0] OFF_STATUS = 4'hA;

    localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYC - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYC - 1);
    localparam logic [5:0]  LAST_STEP   = 6'd34;

    // CRTC R0..R15, R0 in the most significant byte.
    localparam logic [127:0] CRTC_40  = 128'h38_28_2D_0A_1F_06_19_1C_02_07_06_07_00_00_00_00;
    localparam logic [127:0] CRTC_80  = 128'h71_50_5A_0A_1F_06_19_1C_02_07_06_07_00_00_00_00;
    localparam logic [127:0] CRTC_GFX = 128'h38_28_2D_0A_7F_06_64_70_02_01_06_07_00_00_00_00;

    function automatic logic [7:0] crtc_byte(input logic [1:0] m, input logic [3:0] r);
        logic [127:0] tbl;
        case (m)
            2'd0:    tbl = CRTC_40;
            2'd1:    tbl = CRTC_80;
            default: tbl = CRTC_GFX;
        endcase
        tbl = tbl << {r, 3'b000};
        return tbl[127:120];
    endfunction

    function automatic logic [7:0] mode_byte(input logic [1:0] m);
        case (m)
            2'd0:    return 8'h28;
            2'd1:    return 8'h29;
            2'd2:    return 8'h2A;
            default: return 8'h1E;
        endcase
    endfunction

    function automatic logic [7:0] colour_byte(input logic [1:0] m);
        case (m)
            2'd2:    return 8'h30;
            2'd3:    return 8'h3F;
            default: return 8'h00;
        endcase
    endfunction

    logic [2:0]  state_q,   state_d;
    logic [15:0] cnt_q,     cnt_d;
    logic [5:0]  step_q,    step_d;
    logic [1:0]  mode_q,    mode_d;
    logic [15:0] poll_q,    poll_d;
    logic        vs_q,      vs_d;
    logic        timeout_q, timeout_d;

    logic [15:0] poll_nx;
    logic [3:0]  reg_sel;
    logic [3:0]  wr_off;
    logic [7:0]  wr_data;
    logic        in_rd;
    logic        in_wr;
    logic        unused_ok;

    assign poll_nx = poll_q + 16'd1;
    assign unused_ok = ^{bus.bus_in[7:4], bus.bus_in[2:0]};

    // Steps 1..32 alternate index/data; odd steps carry the index of the pair.
    assign reg_sel = step_q[0] ? step_q[4:1] : (step_q[4:1] - 4'd1);

    always_comb begin
        wr_off  = OFF_MODE;
        wr_data = mode_byte(mode_q);
        if (step_q == 6'd0) begin
            wr_off  = OFF_MODE;
            wr_data = mode_byte(mode_q) & 8'hF7;
        end else if (step_q <= 6'd32) begin
            if (step_q[0]) begin
                wr_off  = OFF_INDEX;
                wr_data = {4'b0000, reg_sel};
            end else begin
                wr_off  = OFF_DATA;
                wr_data = crtc_byte(mode_q, reg_sel);
            end
        end else if (step_q == 6'd33) begin
            wr_off  = OFF_COLOUR;
            wr_data = colour_byte(mode_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        mode_d    = mode_q;
        poll_d    = poll_q;
        vs_d      = vs_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = mode_sel;
                    step_d    = 6'd0;
                    poll_d    = 16'd0;
                    cnt_d     = 16'd0;
                    timeout_d = 1'b0;
                    state_d   = (WAIT_VSYNC != 0) ? S_RD_SETUP : S_WR_SETUP;
                end
            end
            S_RD_SETUP, S_WR_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = (state_q == S_RD_SETUP) ? S_RD_STROBE : S_WR_STROBE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RD_STROBE, S_WR_STROBE: begin
                // A not-ready cycle does not count towards the strobe width.
                if (bus.bus_rdy) begin
                    if (cnt_q == STROBE_LAST) begin
                        cnt_d = 16'd0;
                        if (state_q == S_RD_STROBE) begin
                            vs_d    = bus.bus_in[3];
                            state_d = S_RD_HOLD;
                        end else begin
                            state_d = S_WR_HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_RD_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = 16'd0;
                    if (vs_q) begin
                        step_d  = 6'd0;
                        state_d = S_WR_SETUP;
                    end else if (poll_nx == POLL_TIMEOUT) begin
                        poll_d    = poll_nx;
                        timeout_d = 1'b1;
                        step_d    = 6'd0;
                        state_d   = S_WR_SETUP;
                    end else begin
                        poll_d  = poll_nx;
                        state_d = S_RD_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WR_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = 16'd0;
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + 6'd1;
                        state_d = S_WR_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            step_q    <= 6'd0;
            mode_q    <= 2'd0;
            poll_q    <= 16'd0;
            vs_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            mode_q    <= mode_d;
            poll_q    <= poll_d;
            vs_q      <= vs_d;
            timeout_q <= timeout_d;
        end
    end

    // Bus outputs decode straight from state, so a reset edge releases strobes at once.
    assign in_rd = (state_q == S_RD_SETUP) || (state_q == S_RD_STROBE) || (state_q == S_RD_HOLD);
    assign in_wr = (state_q == S_WR_SETUP) || (state_q == S_WR_STROBE) || (state_q == S_WR_HOLD);

    assign bus.bus_aen   = ~(in_rd | in_wr);
    assign bus.bus_ior_l = (state_q != S_RD_STROBE);
    assign bus.bus_iow_l = (state_q != S_WR_STROBE);
    assign bus.bus_a     = in_rd ? (IO_BASE_ADDR[14:0] + {11'd0, OFF_STATUS}) :
                           in_wr ? (IO_BASE_ADDR[14:0] + {11'd0, wr_off}) : 15'd0;
    assign bus.bus_d     = in_wr ? wr_data : 8'd0;

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_cga_mode_init.sv
// Directed bench: one instance with default parameters, one polling vsync with a 4-read limit.
// Bus monitors record every strobe; expected bytes come from the mode tables below.
module tb_cga_mode_init;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_l;
    logic       start_a, start_b;
    logic [1:0] mode_a, mode_b;
    logic       busy_a, done_a, tmo_a;
    logic       busy_b, done_b, tmo_b;

    cga_mode_init_if ifa ();
    cga_mode_init_if ifb ();

    cga_mode_init u_dut_a (
        .clk(clk), .reset_l(reset_l), .start(start_a), .mode_sel(mode_a),
        .busy(busy_a), .done(done_a), .timeout(tmo_a), .bus(ifa)
    );

    cga_mode_init #(.WAIT_VSYNC(1), .POLL_TIMEOUT(16'd4)) u_dut_b (
        .clk(clk), .reset_l(reset_l), .start(start_b), .mode_sel(mode_b),
        .busy(busy_b), .done(done_b), .timeout(tmo_b), .bus(ifb)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] crtc_tab [0:2][0:15] = '{
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70, 8'h02, 8'h01, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}
    };
    logic [7:0] mode_tab [0:3] = '{8'h28, 8'h29, 8'h2A, 8'h1E};
    logic [7:0] col_tab  [0:3] = '{8'h00, 8'h00, 8'h30, 8'h3F};

    // Monitor A: write pulses, strobe widths, done pulses, strobe/aen rule.
    logic [14:0] wa_a [0:511];
    logic [7:0]  wd_a [0:511];
    int          wlen_a [0:511];
    int          wcnt_a = 0;
    int          done_cnt_a = 0;
    logic        piow_a = 1'b1;
    logic        viol_a = 1'b0;

    always @(negedge clk) begin
        if (!ifa.bus_iow_l) begin
            if (piow_a) begin
                wa_a[wcnt_a]   <= ifa.bus_a;
                wd_a[wcnt_a]   <= ifa.bus_d;
                wlen_a[wcnt_a] <= 1;
                wcnt_a         <= wcnt_a + 1;
            end else begin
                wlen_a[wcnt_a-1] <= wlen_a[wcnt_a-1] + 1;
            end
        end
        piow_a <= ifa.bus_iow_l;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if ((!ifa.bus_iow_l || !ifa.bus_ior_l) && ifa.bus_aen) viol_a <= 1'b1;
        if (!ifa.bus_iow_l && !ifa.bus_ior_l) viol_a <= 1'b1;
    end

    // Monitor B: writes plus status reads, noting how many writes preceded each read.
    logic [14:0] wa_b [0:511];
    logic [7:0]  wd_b [0:511];
    int          wcnt_b = 0;
    logic [14:0] ra_b [0:63];
    int          rw_b [0:63];
    int          rcnt_b = 0;
    logic        piow_b = 1'b1;
    logic        pior_b = 1'b1;
    logic        viol_b = 1'b0;

    always @(negedge clk) begin
        if (!ifb.bus_iow_l && piow_b) begin
            wa_b[wcnt_b] <= ifb.bus_a;
            wd_b[wcnt_b] <= ifb.bus_d;
            wcnt_b       <= wcnt_b + 1;
        end
        if (!ifb.bus_ior_l && pior_b) begin
            ra_b[rcnt_b] <= ifb.bus_a;
            rw_b[rcnt_b] <= wcnt_b;
            rcnt_b       <= rcnt_b + 1;
        end
        piow_b <= ifb.bus_iow_l;
        pior_b <= ifb.bus_ior_l;
        if ((!ifb.bus_iow_l || !ifb.bus_ior_l) && ifb.bus_aen) viol_b <= 1'b1;
        if (!ifb.bus_iow_l && !ifb.bus_ior_l) viol_b <= 1'b1;
    end

    // Adapter status: bit3 rises once more than nzero_b reads have started; noise elsewhere.
    int rbase_b = 0;
    int nzero_b = 0;
    assign ifa.bus_in = 8'h00;
    assign ifb.bus_in = ((rcnt_b - rbase_b) > nzero_b) ? 8'h08 : 8'hF7;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void exp_wr(input int m, input int s, output logic [14:0] a, output logic [7:0] d);
        logic [3:0] off;
        int r;
        if (s == 0) begin
            off = 4'h8; d = mode_tab[m] & 8'hF7;
        end else if (s <= 32) begin
            r = (s - 1) / 2;
            if (s % 2 == 1) begin off = 4'h4; d = 8'(r); end
            else begin off = 4'h5; d = crtc_tab[(m == 3) ? 2 : m][r]; end
        end else if (s == 33) begin
            off = 4'h9; d = col_tab[m];
        end else begin
            off = 4'h8; d = mode_tab[m];
        end
        a = 15'h3D0 + {11'd0, off};
    endfunction

    task automatic check_seq(input bit b, input int m, input int base);
        logic [14:0] ea, ga;
        logic [7:0]  ed, gd;
        for (int s = 0; s < 35; s++) begin
            exp_wr(m, s, ea, ed);
            ga = b ? wa_b[base+s] : wa_a[base+s];
            gd = b ? wd_b[base+s] : wd_a[base+s];
            chk($sformatf("%s_m%0d_s%0d_addr", b ? "b" : "a", m, s), 32'(ga), 32'(ea));
            chk($sformatf("%s_m%0d_s%0d_data", b ? "b" : "a", m, s), 32'(gd), 32'(ed));
        end
    endtask

    // Pulses start for one cycle; returns at the negedge of cycle 1 (t0 marks cycle 0).
    task automatic pulse_start(input bit b, input logic [1:0] m);
        @(negedge clk);
        if (b) begin mode_b = m; start_b = 1'b1; end
        else   begin mode_a = m; start_a = 1'b1; end
        t0 = cyc;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit b, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 3000; i++) begin
            if (b ? done_b : done_a) begin
                dcyc = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        chk(b ? "b_done_seen" : "a_done_seen", 32'(dcyc >= 0), 32'd1);
    endtask

    int wb, rb, dc, dn0;

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_l = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        mode_a = 2'd0;  mode_b = 2'd0;
        ifa.bus_rdy = 1'b1;
        ifb.bus_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_timeout", tmo_a, 1'b0);
        chk("rst_ior", ifa.bus_ior_l, 1'b1);
        chk("rst_iow", ifa.bus_iow_l, 1'b1);
        chk("rst_aen", ifa.bus_aen, 1'b1);
        chk("rst_addr", 32'(ifa.bus_a), 32'd0);
        chk("rst_data", 32'(ifa.bus_d), 32'd0);
        chk("rst_b_ior", ifb.bus_ior_l, 1'b1);
        reset_l = 1'b1;
        @(negedge clk);

        // Mode 1, extra starts while busy and in the DONE cycle.
        wb = wcnt_a; dn0 = done_cnt_a;
        pulse_start(1'b0, 2'd1);
        chk("m1_busy_c1", busy_a, 1'b1);
        while (cyc - t0 < 100) @(negedge clk);
        mode_a = 2'd2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, dc);
        chk("m1_done_cycle", 32'(dc), 32'd281);
        chk("m1_busy_at_done", busy_a, 1'b0);
        chk("m1_aen_at_done", ifa.bus_aen, 1'b1);
        mode_a = 2'd3; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("m1_busy_after", busy_a, 1'b0);
        chk("m1_done_pulses", 32'(done_cnt_a - dn0), 32'd1);
        chk("m1_writes", 32'(wcnt_a - wb), 32'd35);
        chk("m1_first_addr", 32'(wa_a[wb]), 32'h3D8);
        chk("m1_first_data", 32'(wd_a[wb]), 32'h21);
        chk("m1_third_addr", 32'(wa_a[wb+2]), 32'h3D5);
        chk("m1_third_data", 32'(wd_a[wb+2]), 32'h71);
        chk("m1_last_addr", 32'(wa_a[wb+34]), 32'h3D8);
        chk("m1_last_data", 32'(wd_a[wb+34]), 32'h29);
        chk("m1_strobe_len", 32'(wlen_a[wb]), 32'd4);
        check_seq(1'b0, 1, wb);

        // Mode 3 with rdy low for 10 cycles inside the step-5 strobe.
        wb = wcnt_a;
        pulse_start(1'b0, 2'd3);
        for (int i = 0; i < 1000 && (wcnt_a - wb) < 6; i++) @(negedge clk);
        chk("m3_reached_step5", ifa.bus_iow_l, 1'b0);
        ifa.bus_rdy = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        ifa.bus_rdy = 1'b1;
        wait_done(1'b0, dc);
        chk("m3_done_cycle", 32'(dc), 32'd291);
        chk("m3_stall_len", 32'(wlen_a[wb+5]), 32'd14);
        chk("m3_prev_len", 32'(wlen_a[wb+4]), 32'd4);
        repeat (2) @(negedge clk);
        chk("m3_writes", 32'(wcnt_a - wb), 32'd35);
        check_seq(1'b0, 3, wb);

        // Reset during the step-10 strobe, then a clean mode 2 run.
        wb = wcnt_a;
        pulse_start(1'b0, 2'd0);
        for (int i = 0; i < 1000 && (wcnt_a - wb) < 11; i++) @(negedge clk);
        chk("rst10_in_strobe", ifa.bus_iow_l, 1'b0);
        reset_l = 1'b0;
        @(negedge clk);
        chk("rst10_iow", ifa.bus_iow_l, 1'b1);
        chk("rst10_aen", ifa.bus_aen, 1'b1);
        chk("rst10_busy", busy_a, 1'b0);
        chk("rst10_addr", 32'(ifa.bus_a), 32'd0);
        reset_l = 1'b1;
        @(negedge clk);
        wb = wcnt_a;
        pulse_start(1'b0, 2'd2);
        wait_done(1'b0, dc);
        chk("m2_done_cycle", 32'(dc), 32'd281);
        repeat (2) @(negedge clk);
        chk("m2_writes", 32'(wcnt_a - wb), 32'd35);
        check_seq(1'b0, 2, wb);
        chk("a_strobe_rules", viol_a, 1'b0);

        // Vsync found on the fourth status read.
        rbase_b = rcnt_b; nzero_b = 3; wb = wcnt_b;
        pulse_start(1'b1, 2'd0);
        wait_done(1'b1, dc);
        chk("vs_done_cycle", 32'(dc), 32'd313);
        chk("vs_timeout", tmo_b, 1'b0);
        repeat (2) @(negedge clk);
        chk("vs_reads", 32'(rcnt_b - rbase_b), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("vs_read%0d_addr", i), 32'(ra_b[rbase_b+i]), 32'h3DA);
            chk($sformatf("vs_read%0d_before_wr", i), 32'(rw_b[rbase_b+i]), 32'(wb));
        end
        chk("vs_writes", 32'(wcnt_b - wb), 32'd35);
        check_seq(1'b1, 0, wb);

        // Bit3 stuck low: four reads, timeout, full sequence anyway.
        rb = rcnt_b; rbase_b = rb; nzero_b = 1000; wb = wcnt_b;
        pulse_start(1'b1, 2'd3);
        wait_done(1'b1, dc);
        chk("to_done_cycle", 32'(dc), 32'd313);
        chk("to_timeout", tmo_b, 1'b1);
        repeat (2) @(negedge clk);
        chk("to_timeout_sticky", tmo_b, 1'b1);
        chk("to_reads", 32'(rcnt_b - rb), 32'd4);
        chk("to_writes", 32'(wcnt_b - wb), 32'd35);
        check_seq(1'b1, 3, wb);

        // A new start clears timeout; vsync present on the first read.
        rb = rcnt_b; rbase_b = rb; nzero_b = 0; wb = wcnt_b;
        pulse_start(1'b1, 2'd1);
        chk("clr_timeout", tmo_b, 1'b0);
        wait_done(1'b1, dc);
        chk("clr_done_cycle", 32'(dc), 32'd289);
        repeat (2) @(negedge clk);
        chk("clr_reads", 32'(rcnt_b - rb), 32'd1);
        chk("clr_writes", 32'(wcnt_b - wb), 32'd35);
        chk("b_strobe_rules", viol_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
